seg_rotate_ctrl: RTL and testbench

- Controller for the 4-digit seven-segment display. It generates a "circling square" animation that walks around the four digits.
- It owns digit-scan multiplexing (anode sequencing), the step prescaler and the rotation position state machine.
- Direction is switch-selected, clockwise or counter-clockwise. Reversing direction continues from the current position with no jump.
- Drives an/sseg of the board display directly.

---
 rtl/seg_rotate_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_rotate_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg_rotate_ctrl.sv
// seg_rotate_ctrl
//   "Circling square" animation controller for a 4-digit seven-segment display.
//   A lit square walks across the upper half of the digits (d3 -> d0) and back
//   along the lower half (d0 -> d3). Direction comes from a switch. Reversing
//   direction continues from the current position.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-low reset
//   en     in   async switch, 1 = rotation advances, 0 = freeze (scan continues)
//   dir    in   async switch, 0 = clockwise (pos+1), 1 = counter-clockwise (pos-1)
//   speed  in   [1:0] step rate 1x/2x/4x/8x (only with SPEED_SEL_EN)
//   an     out  [3:0] anode enables, active-low, one-hot-low
//   sseg   out  [7:0] segments, active-low, bit0=a .. bit6=g, bit7=dp
//   pos    out  [2:0] current rotation position (debug)
//
// Optional feature macro: SPEED_SEL_EN adds the speed input.
//   Terminal count = (STEP_DIV >> speed) - 1.

module seg_rotate_ctrl #(
  parameter int REFRESH_BITS = 18,
  parameter int STEP_DIV     = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
`ifdef SPEED_SEL_EN
  input  logic [1:0] speed,
`endif
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic [2:0] pos
);

  localparam int PW = $clog2(STEP_DIV);

  localparam logic [7:0] PAT_UP  = 8'h9C;  // a,b,f,g lit
  localparam logic [7:0] PAT_LO  = 8'hA3;  // c,d,e,g lit
  localparam logic [7:0] PAT_OFF = 8'hFF;

  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, P7} pos_e;

  // Two-flop synchronizers for the switches.
  logic en_meta_q, en_s_q;
  logic dir_meta_q, dir_s_q;

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [PW-1:0]           presc_q, presc_d;
  pos_e                    pos_q, pos_d;
  logic [3:0]              an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;

  logic [PW-1:0] term;
  logic          tick;
  logic [1:0]    sel;
  logic [1:0]    dig;
  logic [7:0]    pat;

`ifdef SPEED_SEL_EN
  logic [1:0]  spd_meta_q, spd_s_q;
  logic [31:0] div_w;

  assign div_w = 32'(STEP_DIV) >> spd_s_q;
  // Guard against a shifted divider of 0 or 1: step every cycle then.
  assign term  = (div_w > 32'd1) ? PW'(div_w - 32'd1) : '0;
`else
  assign term  = PW'(STEP_DIV - 1);
`endif

  // ">=" rather than "==" so that lowering the terminal below the current
  // count fires on the next cycle instead of waiting for a full wrap.
  assign tick = en_s_q && (presc_q >= term);
  assign sel  = cnt_q[REFRESH_BITS-1 -: 2];

  // Prescaler: holds while frozen, resumes from the held count.
  always_comb begin
    presc_d = presc_q;
    if (en_s_q) begin
      if (tick) presc_d = '0;
      else      presc_d = presc_q + 1'b1;
    end
  end

  // Position FSM: direction is sampled only in the tick cycle.
  always_comb begin
    pos_d = pos_q;
    if (tick) begin
      if (dir_s_q) pos_d = pos_e'(3'(pos_q - 3'd1));
      else         pos_d = pos_e'(3'(pos_q + 3'd1));
    end
  end

  // Position -> (digit, pattern). P0..P3 walk the upper squares from d3 to d0,
  // P4..P7 walk the lower squares back from d0 to d3.
  always_comb begin
    dig = 2'd3;
    pat = PAT_UP;
    case (pos_q)
      P0: begin dig = 2'd3; pat = PAT_UP; end
      P1: begin dig = 2'd2; pat = PAT_UP; end
      P2: begin dig = 2'd1; pat = PAT_UP; end
      P3: begin dig = 2'd0; pat = PAT_UP; end
      P4: begin dig = 2'd0; pat = PAT_LO; end
      P5: begin dig = 2'd1; pat = PAT_LO; end
      P6: begin dig = 2'd2; pat = PAT_LO; end
      P7: begin dig = 2'd3; pat = PAT_LO; end
      default: begin dig = 2'd3; pat = PAT_OFF; end
    endcase
  end

  always_comb begin
    an_d   = ~(4'b0001 << sel);
    sseg_d = (sel == dig) ? pat : PAT_OFF;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_meta_q  <= 1'b0;
      en_s_q     <= 1'b0;
      dir_meta_q <= 1'b0;
      dir_s_q    <= 1'b0;
`ifdef SPEED_SEL_EN
      spd_meta_q <= 2'd0;
      spd_s_q    <= 2'd0;
`endif
      cnt_q      <= '0;
      presc_q    <= '0;
      pos_q      <= P0;
      an_q       <= 4'hF;
      sseg_q     <= PAT_OFF;
    end else begin
      en_meta_q  <= en;
      en_s_q     <= en_meta_q;
      dir_meta_q <= dir;
      dir_s_q    <= dir_meta_q;
`ifdef SPEED_SEL_EN
      spd_meta_q <= speed;
      spd_s_q    <= spd_meta_q;
`endif
      cnt_q      <= cnt_q + 1'b1;
      presc_q    <= presc_d;
      pos_q      <= pos_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;
  assign pos  = pos_q;

endmodule

// File: tb/tb_seg_rotate_ctrl.sv
// Directed bench for seg_rotate_ctrl with REFRESH_BITS=4, STEP_DIV=8.
// Each table row drives {reset, en, dir} up to an absolute cycle index k
// (posedges after the initial reset release) and then checks pos/an/sseg.
module tb_seg_rotate_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       dir;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [2:0] pos;
`ifdef SPEED_SEL_EN
  logic [1:0] speed;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int k       = 0;

  seg_rotate_ctrl #(.REFRESH_BITS(4), .STEP_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .dir   (dir),
`ifdef SPEED_SEL_EN
    .speed (speed),
`endif
    .an    (an),
    .sseg  (sseg),
    .pos   (pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         until_k;
    logic       rst;
    logic       en;
    logic       dir;
    logic [2:0] pos;
    logic [3:0] an;
    logic [7:0] sseg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int u, logic r, logic e, logic d,
                              logic [2:0] p, logic [3:0] a, logic [7:0] s);
    vec_t v;
    v.until_k = u; v.rst = r; v.en = e; v.dir = d;
    v.pos = p; v.an = a; v.sseg = s;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d: got %h, expected %h", nm, k, act, exp);
  endtask

  task automatic step_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;
`ifdef SPEED_SEL_EN
    speed = 2'd0;
`endif
    // Columns: until_k, rst, en, dir, pos, an, sseg
    tbl.push_back(mk(  1, 1, 0, 0, 3'd0, 4'hE, 8'hFF));  // first scan digit
    tbl.push_back(mk(  9, 1, 0, 0, 3'd0, 4'hB, 8'hFF));
    tbl.push_back(mk( 13, 1, 0, 0, 3'd0, 4'h7, 8'h9C));  // d3 upper shown
    tbl.push_back(mk( 16, 1, 0, 0, 3'd0, 4'h7, 8'h9C));
    tbl.push_back(mk( 25, 1, 1, 0, 3'd0, 4'hB, 8'hFF));  // en on, sync delay
    tbl.push_back(mk( 26, 1, 1, 0, 3'd1, 4'hB, 8'hFF));  // first tick
    tbl.push_back(mk( 27, 1, 1, 0, 3'd1, 4'hB, 8'h9C));  // d2 upper, 1-cycle lag
    tbl.push_back(mk( 45, 1, 1, 0, 3'd3, 4'h7, 8'hFF));
    tbl.push_back(mk( 49, 1, 1, 0, 3'd3, 4'hE, 8'h9C));  // d0 upper
    tbl.push_back(mk( 51, 1, 1, 0, 3'd4, 4'hE, 8'hA3));  // d0 lower
    tbl.push_back(mk( 77, 1, 1, 0, 3'd7, 4'h7, 8'hA3));  // d3 lower
    tbl.push_back(mk( 81, 1, 1, 0, 3'd7, 4'hE, 8'hFF));
    tbl.push_back(mk( 82, 1, 1, 0, 3'd0, 4'hE, 8'hFF));  // wrap up 7->0
    tbl.push_back(mk( 97, 1, 1, 0, 3'd1, 4'hE, 8'hFF));
    tbl.push_back(mk( 98, 1, 1, 0, 3'd2, 4'hE, 8'hFF));
    tbl.push_back(mk(100, 1, 1, 0, 3'd2, 4'hE, 8'hFF));
    tbl.push_back(mk(102, 1, 1, 1, 3'd2, 4'hD, 8'h9C));  // dir flipped, no jump
    tbl.push_back(mk(105, 1, 1, 1, 3'd2, 4'hB, 8'hFF));
    tbl.push_back(mk(106, 1, 1, 1, 3'd1, 4'hB, 8'hFF));  // steps down
    tbl.push_back(mk(114, 1, 1, 1, 3'd0, 4'hE, 8'hFF));
    tbl.push_back(mk(122, 1, 1, 1, 3'd7, 4'hB, 8'hFF));  // wrap down 0->7
    tbl.push_back(mk(130, 1, 1, 1, 3'd6, 4'hE, 8'hFF));
    tbl.push_back(mk(133, 1, 1, 1, 3'd6, 4'hD, 8'hFF));  // prescaler = 3
    tbl.push_back(mk(166, 1, 0, 1, 3'd6, 4'hD, 8'hFF));  // frozen at 5
    tbl.push_back(mk(170, 1, 0, 1, 3'd6, 4'hB, 8'hA3));  // still scanning
    tbl.push_back(mk(173, 1, 0, 1, 3'd6, 4'h7, 8'hFF));
    tbl.push_back(mk(177, 1, 1, 1, 3'd6, 4'hE, 8'hFF));  // re-enabled at 174
    tbl.push_back(mk(178, 1, 1, 1, 3'd5, 4'hE, 8'hFF));  // tick 2+3 later
    tbl.push_back(mk(185, 1, 1, 0, 3'd5, 4'hB, 8'hFF));
    tbl.push_back(mk(186, 1, 1, 0, 3'd6, 4'hB, 8'hFF));
    tbl.push_back(mk(189, 1, 1, 0, 3'd6, 4'h7, 8'hFF));
    tbl.push_back(mk(190, 0, 1, 0, 3'd0, 4'hF, 8'hFF));  // reset mid-interval
    tbl.push_back(mk(191, 1, 1, 0, 3'd0, 4'hE, 8'hFF));
    tbl.push_back(mk(199, 1, 1, 0, 3'd0, 4'hB, 8'hFF));  // prescaler restarted
    tbl.push_back(mk(200, 1, 1, 0, 3'd1, 4'hB, 8'hFF));
    tbl.push_back(mk(201, 1, 1, 0, 3'd1, 4'hB, 8'h9C));

    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",   {4'h0, an}, 8'h0F);
    chk("rst_sseg", sseg,       8'hFF);
    chk("rst_pos",  {5'd0, pos}, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      en    = tbl[i].en;
      dir   = tbl[i].dir;
      step_to(tbl[i].until_k);
      chk($sformatf("v%0d_pos", i),  {5'd0, pos}, {5'd0, tbl[i].pos});
      chk($sformatf("v%0d_an", i),   {4'd0, an},  {4'd0, tbl[i].an});
      chk($sformatf("v%0d_sseg", i), sseg,        tbl[i].sseg);
    end

`ifdef SPEED_SEL_EN
    // Drop the terminal to 1 while the prescaler sits above it.
    step_to(202);
    chk("spd_pre_pos", {5'd0, pos}, 8'd1);
    speed = 2'd2;
    step_to(204);                            // prescaler = 4, speed just synced
    chk("spd_hold_pos", {5'd0, pos}, 8'd1);
    step_to(205);
    chk("spd_tick_pos", {5'd0, pos}, 8'd2);
    step_to(206);
    chk("spd_gap_pos",  {5'd0, pos}, 8'd2);
    step_to(207);
    chk("spd_x4_pos",   {5'd0, pos}, 8'd3);
    step_to(209);
    chk("spd_x4b_pos",  {5'd0, pos}, 8'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
